mac_out_packer: RTL and testbench

MAC_OUT_PACKER -- requirements
Module: mac_out_packer

---
 rtl/mac_out_pkg.sv | 15 +
 rtl/mac_out_packer_sync_fifo.sv | 49 ++++
 rtl/mac_out_packer.sv | 128 ++++++++++++
 tb/tb_mac_out_packer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_out_pkg.sv
// Shared types and constants for the MAC output packer.
// Frame counter width and beats per word live here.
package mac_out_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int FRAME_W = 16;
    localparam int BEATS   = 2;

    typedef logic [FRAME_W-1:0] frame_cnt_t;

endpackage

// File: rtl/mac_out_packer_sync_fifo.sv
// Synchronous FIFO with registered storage and an occupancy count.
// Push and pop may coincide, including when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    // Depth is a power of two, so the count MSB alone means full.
    assign rdata = mem[rptr];
    assign full  = count[AW];
    assign empty = (count == '0);

endmodule

// File: rtl/mac_out_packer.sv
// Buffers wide MAC output words and emits each as two half-word beats,
// framing them with a last flag and a frame-done pulse.
module mac_out_packer
    import mac_out_pkg::*;
#(
    parameter int MAC_OUT_NUM = 18,
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   start_i,
    input  logic [FRAME_W-1:0]                     frame_len_i,
    input  logic [MAC_OUT_NUM*DATA_WIDTH-1:0]      in_data_i,
    input  logic                                   in_valid_i,
    output logic                                   in_afull_o,
    output logic [MAC_OUT_NUM*DATA_WIDTH/BEATS-1:0] out_data_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic                                   out_last_o,
    output logic                                   frame_done_o,
    output logic                                   overflow_o
);

    localparam int WW = MAC_OUT_NUM * DATA_WIDTH;
    localparam int BW = WW / BEATS;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] AFULL = CW'(FIFO_DEPTH - 2);

    state_t     state;
    state_t     state_nxt;
    frame_cnt_t frame_len;
    frame_cnt_t acc_cnt;
    logic       sel;
    logic       done_q;
    logic       done_nxt;

    logic          f_push;
    logic          f_pop;
    logic [WW:0]   f_wdata;
    logic [WW:0]   f_rdata;
    logic          f_full;
    logic          f_empty;
    logic [CW-1:0] f_count;

    logic want;
    logic room;
    logic drop;
    logic start_go;
    logic hs;
    logic end_last;
    logic end_drain;

    // The top bit of each entry marks the frame's final word.
    assign f_wdata   = {acc_cnt == frame_len - 1'b1, in_data_i};
    assign hs        = out_valid_o & out_ready_i;
    assign f_pop     = hs & sel;
    assign want      = (state == RUN) & in_valid_i & (acc_cnt < frame_len);
    assign room      = ~f_full | f_pop;
    assign f_push    = want & room;
    assign drop      = want & ~room;
    assign start_go  = (state == IDLE) & start_i & (frame_len_i != '0);
    assign end_last  = f_pop & f_rdata[WW];
    assign end_drain = (state == RUN) & (acc_cnt == frame_len) & f_empty;

    sync_fifo #(
        .WIDTH (WW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (f_push),
        .wdata (f_wdata),
        .pop   (f_pop),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_go) state_nxt = RUN;
                if (start_i && frame_len_i == '0) done_nxt = 1'b1;
            end
            RUN: begin
                if (end_last || end_drain) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            frame_len  <= '0;
            acc_cnt    <= '0;
            sel        <= 1'b0;
            done_q     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            if (hs) sel <= ~sel;
            if (start_go) begin
                frame_len  <= frame_len_i;
                acc_cnt    <= '0;
                overflow_o <= 1'b0;
            end else if (want) begin
                acc_cnt <= acc_cnt + 1'b1;
                if (drop) overflow_o <= 1'b1;
            end
        end
    end

    assign out_valid_o  = ~f_empty;
    assign out_last_o   = out_valid_o & sel & f_rdata[WW];
    assign out_data_o   = ~out_valid_o ? '0 :
                          sel ? f_rdata[BW +: BW] : f_rdata[0 +: BW];
    assign in_afull_o   = (f_count >= AFULL);
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_mac_out_packer.sv
// Scoreboard bench for mac_out_packer: directed frames,
// expected beats queued at issue and checked by a monitor.
module tb_mac_out_packer;

    localparam int N  = 18;
    localparam int WW = N * 8;
    localparam int BW = WW / 2;

    typedef struct packed {
        logic [BW-1:0] d;
        logic          l;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_i;
    logic [15:0]   frame_len_i;
    logic [WW-1:0] in_data_i;
    logic          in_valid_i;
    logic          in_afull_o;
    logic [BW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          out_last_o;
    logic          frame_done_o;
    logic          overflow_o;

    mac_out_packer dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start_i),
        .frame_len_i  (frame_len_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_afull_o   (in_afull_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_last_o   (out_last_o),
        .frame_done_o (frame_done_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int   nvec = 0;
    int   nerr = 0;
    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    int   done_cnt = 0;
    bit   done_pend = 0;

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] val(input int kind, input logic [7:0] b,
                                       input int c);
        return (kind == 0) ? b : 8'(c);
    endfunction

    function automatic logic [WW-1:0] mkw(input int kind, input logic [7:0] b);
        logic [WW-1:0] w;
        for (int c = 0; c < N; c++) w[c*8 +: 8] = val(kind, b, c);
        return w;
    endfunction

    function automatic exp_t mkbeat(input int kind, input logic [7:0] b,
                                    input int h, input bit last);
        exp_t x;
        for (int k = 0; k < N / 2; k++) x.d[k*8 +: 8] = val(kind, b, h * (N / 2) + k);
        x.l = last;
        return x;
    endfunction

    // Monitor: every handshake pops one expected beat.
    always @(negedge clk) begin
        cyc++;
        if (rstn && frame_done_o) done_cnt++;
        if (done_pend) begin
            chk("done_after_last", frame_done_o, 1'b1);
            done_pend = 0;
        end
        if (out_valid_o && out_ready_i) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", out_data_o, '0);
                chk("unexpected_beat_valid", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                chk("beat_data", out_data_o, e.d);
                chk("beat_last", out_last_o, e.l);
            end
            if (hs_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            hs_cnt++;
            if (out_last_o) done_pend = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nwait();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        hs_cnt = 0;
        first_cyc = 0;
        last_cyc = 0;
    endtask

    task automatic issue(input int kind, input logic [7:0] b,
                         input bit acc, input bit last);
        in_valid_i = 1'b1;
        in_data_i  = mkw(kind, b);
        if (acc) begin
            q.push_back(mkbeat(kind, b, 0, 1'b0));
            q.push_back(mkbeat(kind, b, 1, last));
        end
    endtask

    task automatic start(input logic [15:0] len);
        start_i     = 1'b1;
        frame_len_i = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((q.size() != 0 || out_valid_o) && n < max) begin
            nwait();
            n++;
        end
        chk("drain_in_time", n < max, 1'b1);
    endtask

    task automatic wait_done(input int base, input int max);
        int n = 0;
        while (done_cnt == base && n < max) begin
            nwait();
            n++;
        end
        chk("done_in_time", n < max, 1'b1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, out_valid_o, 1'b0);
        chk({nm, "_last"}, out_last_o, 1'b0);
        chk({nm, "_done"}, frame_done_o, 1'b0);
        chk({nm, "_ovf"}, overflow_o, 1'b0);
        chk({nm, "_afull"}, in_afull_o, 1'b0);
        chk({nm, "_data"}, out_data_o, '0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        rstn        = 1'b0;
        start_i     = 1'b0;
        frame_len_i = '0;
        in_data_i   = '0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        tick();
        rstn = 1'b1;
        tick();

        // Three-word frame, sink always ready.
        out_ready_i = 1'b1;
        clr();
        base = done_cnt;
        start(16'd3);
        issue(0, 8'h01, 1, 0); tick();
        issue(0, 8'h02, 1, 0); tick();
        issue(0, 8'h03, 1, 1); tick();
        in_valid_i = 1'b0;
        wait_drain(50);
        nwait(); nwait();
        chk("f3_beats", hs_cnt, 6);
        chk("f3_b2b", last_cyc - first_cyc, 5);
        chk("f3_done_cnt", done_cnt - base, 1);

        // Channel-index pattern and single-cycle latency.
        clr();
        start(16'd1);
        issue(1, 8'h00, 1, 1); tick();
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("lat_valid", out_valid_o, 1'b1);
        chk("lat_beat0", out_data_o, 72'h08_07_06_05_04_03_02_01_00);
        wait_drain(50);
        nwait(); nwait();
        chk("ramp_beats", hs_cnt, 2);

        // Stalled sink: almost-full, overflow, drain without last.
        out_ready_i = 1'b0;
        clr();
        start(16'd5);
        for (int i = 0; i < 4; i++) begin
            issue(0, 8'(8'h10 + i), 1, 0);
            tick();
            in_valid_i = 1'b0;
            @(negedge clk);
            chk("afull_occ", in_afull_o, i >= 1);
            tick();
        end
        chk("ovf_before", overflow_o, 1'b0);
        chk("stall_valid", out_valid_o, 1'b1);
        chk("stall_data", out_data_o, {9{8'h10}});
        chk("stall_last", out_last_o, 1'b0);
        issue(0, 8'h14, 0, 0); tick();
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("ovf_set", overflow_o, 1'b1);
        chk("stall_data_hold", out_data_o, {9{8'h10}});
        tick();
        base = done_cnt;
        out_ready_i = 1'b1;
        wait_drain(50);
        wait_done(base, 20);
        chk("ovf_beats", hs_cnt, 8);
        chk("ovf_sticky", overflow_o, 1'b1);

        // Push into a full FIFO on the same cycle as the beat1 pop.
        out_ready_i = 1'b0;
        clr();
        base = done_cnt;
        start(16'd5);
        chk("ovf_cleared", overflow_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            issue(0, 8'(8'h20 + i), 1, 0);
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        issue(0, 8'h24, 1, 1); tick();
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("full_pop_ovf", overflow_o, 1'b0);
        chk("full_pop_afull", in_afull_o, 1'b1);
        wait_drain(50);
        nwait(); nwait();
        chk("full_pop_beats", hs_cnt, 10);
        chk("full_pop_done", done_cnt - base, 1);

        // Zero-length frame, idle drops, start ignored in RUN.
        clr();
        base = done_cnt;
        issue(0, 8'h55, 0, 0); tick();
        in_valid_i = 1'b0;
        start(16'd0);
        @(negedge clk);
        chk("zero_done", frame_done_o, 1'b1);
        chk("zero_novalid", out_valid_o, 1'b0);
        @(negedge clk);
        chk("zero_done_pulse", frame_done_o, 1'b0);
        tick();
        start(16'd2);
        issue(0, 8'h61, 1, 0); tick();
        start_i = 1'b1;
        frame_len_i = 16'd9;
        issue(0, 8'h62, 1, 1); tick();
        start_i = 1'b0;
        issue(0, 8'h63, 0, 0); tick();
        in_valid_i = 1'b0;
        chk("beyond_len_ovf", overflow_o, 1'b0);
        wait_drain(50);
        nwait(); nwait();
        chk("run_start_beats", hs_cnt, 4);
        chk("run_start_done", done_cnt - base, 2);

        // Reset mid-frame with two words buffered.
        out_ready_i = 1'b0;
        clr();
        start(16'd4);
        issue(0, 8'h71, 0, 0); tick();
        issue(0, 8'h72, 0, 0); tick();
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_afull", in_afull_o, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk_zero("mid_rst");
        q.delete();
        tick();
        rstn = 1'b1;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(0, 8'(8'h80 + i), 0, 0);
            tick();
        end
        in_valid_i = 1'b0;
        nwait(); nwait();
        chk("post_rst_silent", hs_cnt, 0);
        start(16'd1);
        issue(0, 8'h90, 1, 1); tick();
        in_valid_i = 1'b0;
        wait_drain(50);
        nwait(); nwait();
        chk("post_rst_beats", hs_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
